// File: rtl/draw_player_pkg.sv
// Shared definitions for the player sprite overlay: geometry, colour key,
// player states, animation frame indices and the pipeline's video bundle.
package draw_player_pkg;

    localparam int PLAYER_W = 32;
    localparam int PLAYER_H = 32;
    localparam int PLAYER_FRAMES = 5;
    localparam logic [11:0] PLAYER_TRANSPARENT = 12'hF0F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        JUMP   = 2'd2,
        FALL   = 2'd3
    } player_state_t;

    localparam logic [2:0] FR_IDLE0  = 3'd0;
    localparam logic [2:0] FR_IDLE1  = 3'd1;
    localparam logic [2:0] FR_CHARGE = 3'd2;
    localparam logic [2:0] FR_JUMP   = 3'd3;
    localparam logic [2:0] FR_FALL   = 3'd4;

    typedef struct packed {
        logic [11:0] vcount;
        logic [11:0] hcount;
        logic        vsync;
        logic        hsync;
        logic        vblnk;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_sig_t;

    // Built-in sprite sheet pattern: colour encodes frame/row/column, frame 0
    // is fully opaque and the bottom row of every other frame is the colour key.
    function automatic logic [11:0] player_art(input logic [12:0] addr);
        logic [11:0] px;
        if (addr[12:10] != 3'd0 && addr[9:5] == 5'd31) begin
            px = PLAYER_TRANSPARENT;
        end else begin
            px = {addr[12:10], addr[8:5], addr[4:0]};
        end
        return px;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pipeline bundle: timing counters, sync/blank strobes and pixel colour.
interface vga_if;
    logic [11:0] vcount;
    logic [11:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/player_rom.sv
// Player sprite sheet: frames stacked by frame index, rows of SPRITE_W pixels,
// combinational read.
module player_rom
    import draw_player_pkg::*;
#(
    parameter int DEPTH = PLAYER_FRAMES * PLAYER_W * PLAYER_H
) (
    input  logic [12:0] addr_i,
    output logic [11:0] data_o
);

    assign data_o = (int'(addr_i) < DEPTH) ? player_art(addr_i) : PLAYER_TRANSPARENT;

endmodule

// File: rtl/draw_player.sv
// Player overlay stage: samples position/state/facing once per frame at the
// start of vertical blanking and overlays the animated, mirrorable sprite.
module draw_player
    import draw_player_pkg::*;
#(
    parameter int          SPRITE_W        = PLAYER_W,
    parameter int          SPRITE_H        = PLAYER_H,
    parameter int          NUM_FRAMES      = PLAYER_FRAMES,
    parameter int          ANIM_PERIOD     = 15,
    parameter logic [11:0] TRANSPARENT_RGB = PLAYER_TRANSPARENT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pos_x,
    input  logic [11:0] pos_y,
    input  logic [1:0]  state,
    input  logic        facing,
    vga_if.in           vga_in,
    vga_if.out          vga_out
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    logic          vblnk_prev_q;
    logic          frame_start;
    logic [11:0]   sx_q, sy_q;
    player_state_t sst_q;
    logic          sface_q;
    logic          valid_q;
    logic [3:0]    anim_cnt_q;
    logic          idle_phase_q;

    logic [2:0]    frame_idx;
    logic [12:0]   dx, dy;
    logic [CW-1:0] col;
    logic [12:0]   addr_d, addr_q;
    logic          in_box_d, in_box_q;
    logic [11:0]   pix;
    vga_sig_t      s1_d, s1_q, s2_d, s2_q;

    assign frame_start = vga_in.vblnk && !vblnk_prev_q;

    // Idle animation only advances across frames already shown as IDLE, so a
    // fresh IDLE spell always begins on frame 0 for a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            sx_q         <= '0;
            sy_q         <= '0;
            sst_q        <= IDLE;
            sface_q      <= 1'b0;
            valid_q      <= 1'b0;
            anim_cnt_q   <= '0;
            idle_phase_q <= 1'b0;
        end else begin
            vblnk_prev_q <= vga_in.vblnk;
            if (frame_start) begin
                sx_q    <= pos_x;
                sy_q    <= pos_y;
                sst_q   <= player_state_t'(state);
                sface_q <= facing;
                valid_q <= 1'b1;
                if (player_state_t'(state) != IDLE) begin
                    anim_cnt_q   <= '0;
                    idle_phase_q <= 1'b0;
                end else if (valid_q && sst_q == IDLE) begin
                    if (anim_cnt_q == 4'(ANIM_PERIOD - 1)) begin
                        anim_cnt_q   <= '0;
                        idle_phase_q <= ~idle_phase_q;
                    end else begin
                        anim_cnt_q <= anim_cnt_q + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        frame_idx = FR_IDLE0;
        unique case (sst_q)
            IDLE:   frame_idx = idle_phase_q ? FR_IDLE1 : FR_IDLE0;
            CHARGE: frame_idx = FR_CHARGE;
            JUMP:   frame_idx = FR_JUMP;
            FALL:   frame_idx = FR_FALL;
        endcase
    end

    // A 13-bit difference of 12-bit values goes "negative" (huge) when the beam
    // is left of/above the sprite, so one unsigned compare covers both bounds.
    assign dx = {1'b0, vga_in.hcount} - {1'b0, sx_q};
    assign dy = {1'b0, vga_in.vcount} - {1'b0, sy_q};

    always_comb begin
        in_box_d = valid_q && !vga_in.hblnk && !vga_in.vblnk
                   && (dx < 13'(SPRITE_W)) && (dy < 13'(SPRITE_H));
        col      = sface_q ? CW'(SPRITE_W - 1) - dx[CW-1:0] : dx[CW-1:0];
        addr_d   = 13'(frame_idx) * 13'(SPRITE_W * SPRITE_H)
                   + 13'(dy[RW-1:0]) * 13'(SPRITE_W) + 13'(col);
    end

    assign s1_d = '{vcount: vga_in.vcount, hcount: vga_in.hcount,
                    vsync:  vga_in.vsync,  hsync:  vga_in.hsync,
                    vblnk:  vga_in.vblnk,  hblnk:  vga_in.hblnk,
                    rgb:    vga_in.rgb};

    player_rom #(
        .DEPTH (NUM_FRAMES * SPRITE_W * SPRITE_H)
    ) u_rom (
        .addr_i (addr_q),
        .data_o (pix)
    );

    always_comb begin
        s2_d = s1_q;
        if (in_box_q && pix != TRANSPARENT_RGB) begin
            s2_d.rgb = pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            addr_q   <= '0;
            in_box_q <= 1'b0;
            s2_q     <= '0;
        end else begin
            s1_q     <= s1_d;
            addr_q   <= addr_d;
            in_box_q <= in_box_d;
            s2_q     <= s2_d;
        end
    end

    assign vga_out.vcount = s2_q.vcount;
    assign vga_out.hcount = s2_q.hcount;
    assign vga_out.vsync  = s2_q.vsync;
    assign vga_out.hsync  = s2_q.hsync;
    assign vga_out.vblnk  = s2_q.vblnk;
    assign vga_out.hblnk  = s2_q.hblnk;
    assign vga_out.rgb    = s2_q.rgb;

endmodule

// File: tb/tb_draw_player.sv
// Scoreboard bench for draw_player: the driver pushes hand-derived expected
// pixels, a free-running monitor pops and compares two cycles later.
module tb_draw_player;

    typedef struct {
        int unsigned slot;
        logic [11:0] vc;
        logic [11:0] hc;
        logic        vs;
        logic        hs;
        logic        vb;
        logic        hb;
        logic [11:0] rgb;
    } expItem_t;

    expItem_t    expQ[$];
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] posX, posY;
    logic [1:0]  state;
    logic        facing;
    int          nCompared = 0;
    int          nMismatch = 0;
    int unsigned edgeCnt = 0;
    bit          rstAtEdge = 1'b0;
    bit          rstPrevEdge = 1'b0;

    bit mValid, mFace, mPrevVb;
    int mSx, mSy, mSt, mIdle;

    vga_if vgaIn ();
    vga_if vgaOut ();

    draw_player dut (
        .clk     (clk),
        .rst     (rst),
        .pos_x   (posX),
        .pos_y   (posY),
        .state   (state),
        .facing  (facing),
        .vga_in  (vgaIn),
        .vga_out (vgaOut)
    );

    always #5 clk = ~clk;

    // Expected pixel from the bench's view of the latched frame parameters.
    function automatic logic [11:0] expRgb(int hc, int vc, bit hb, bit vb, logic [11:0] bg);
        int dx, dy, fr, col;
        dx = hc - mSx;
        dy = vc - mSy;
        if (!mValid || hb || vb || dx < 0 || dx > 31 || dy < 0 || dy > 31) return bg;
        fr  = (mSt == 0) ? ((mIdle - 1) / 15) % 2 : mSt + 1;
        col = mFace ? 31 - dx : dx;
        if (fr != 0 && dy == 31) return bg;
        return {3'(fr), 4'(dy), 5'(col)};
    endfunction

    task automatic applyStimulus(input int hc, input int vc, input bit hb, input bit vb, input bit inReset);
        expItem_t e;
        bit fs;
        @(negedge clk);
        rst          = inReset;
        vgaIn.hcount = 12'(hc);
        vgaIn.vcount = 12'(vc);
        vgaIn.hblnk  = hb;
        vgaIn.vblnk  = vb;
        vgaIn.hsync  = ((hc % 5) == 2);
        vgaIn.vsync  = vb && ((hc % 3) == 0);
        vgaIn.rgb    = {4'hA, 8'(hc)};
        if (inReset) begin
            mValid = 0; mFace = 0; mPrevVb = 0;
            mSx = 0; mSy = 0; mSt = 0; mIdle = 0;
            return;
        end
        e.slot = edgeCnt + 2;
        e.vc   = vgaIn.vcount;
        e.hc   = vgaIn.hcount;
        e.vs   = vgaIn.vsync;
        e.hs   = vgaIn.hsync;
        e.vb   = vb;
        e.hb   = hb;
        e.rgb  = expRgb(hc, vc, hb, vb, vgaIn.rgb);
        expQ.push_back(e);
        fs = vb && !mPrevVb;
        mPrevVb = vb;
        if (fs) begin
            mValid = 1; mSx = int'(posX); mSy = int'(posY);
            mSt = int'(state); mFace = facing;
            mIdle = (state == 2'd0) ? mIdle + 1 : 0;
        end
    endtask

    task automatic drawLine(input int vc, input int hFrom, input int hTo);
        for (int hc = hFrom; hc <= hTo; hc++) applyStimulus(hc, vc, hc >= 1024, vc >= 768, 1'b0);
    endtask

    task automatic frameStart();
        for (int i = 0; i < 4; i++) applyStimulus(i, 770, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic checkOutput();
        expItem_t e;
        bit have;
        logic [39:0] got;
        have = 0;
        got = {vgaOut.vcount, vgaOut.hcount, vgaOut.vsync, vgaOut.hsync,
               vgaOut.vblnk, vgaOut.hblnk, vgaOut.rgb};
        while (expQ.size() > 0 && expQ[0].slot < edgeCnt) begin
            e = expQ.pop_front();
            nCompared++; nMismatch++;
            $display("[TB] FAIL lostEntry slot=%0d now=%0d got=none required=checked", e.slot, edgeCnt);
        end
        if (expQ.size() > 0 && expQ[0].slot == edgeCnt) begin
            e = expQ.pop_front();
            have = 1;
        end
        if (rstAtEdge || rstPrevEdge) begin
            nCompared++;
            if (got !== 40'd0) begin
                nMismatch++;
                $display("[TB] FAIL resetOut edge=%0d got=%h required=0", edgeCnt, got);
            end
        end else if (have) begin
            nCompared++;
            if (got[39:12] !== {e.vc, e.hc, e.vs, e.hs, e.vb, e.hb}) begin
                nMismatch++;
                $display("[TB] FAIL timing edge=%0d got=%h required=%h", edgeCnt, got[39:12],
                         {e.vc, e.hc, e.vs, e.hs, e.vb, e.hb});
            end
            nCompared++;
            if (got[11:0] !== e.rgb) begin
                nMismatch++;
                $display("[TB] FAIL rgb hc=%0d vc=%0d got=%h required=%h", e.hc, e.vc, got[11:0], e.rgb);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edgeCnt++;
            rstPrevEdge = rstAtEdge;
            rstAtEdge   = rst;
            #1;
            checkOutput();
        end
    end

    initial begin
        posX = 12'd100; posY = 12'd200; state = 2'd0; facing = 1'b0;
        vgaIn.hcount = '0; vgaIn.vcount = '0; vgaIn.hsync = 1'b0; vgaIn.vsync = 1'b0;
        vgaIn.hblnk = 1'b0; vgaIn.vblnk = 1'b0; vgaIn.rgb = '0;

        // Power-on reset, then a mid-line reset; no sprite until a vblnk edge.
        for (int i = 0; i < 3; i++) applyStimulus(80 + i, 200, 1'b0, 1'b0, 1'b1);
        drawLine(200, 83, 99);
        for (int i = 100; i < 102; i++) applyStimulus(i, 200, 1'b0, 1'b0, 1'b1);
        drawLine(200, 102, 140);

        // Opaque IDLE frame at (100,200), right-facing, with edge rows/columns.
        frameStart();
        drawLine(199, 95, 135);
        drawLine(200, 95, 135);
        drawLine(231, 95, 135);
        drawLine(232, 95, 105);
        drawLine(220, 1018, 1030);

        // Position changes only take effect at the next frame.
        posX = 12'd300;
        drawLine(210, 95, 135);
        frameStart();
        drawLine(210, 295, 335);
        drawLine(210, 95, 105);

        // Mirrored sprite, then colour-key row in the CHARGE frame.
        posX = 12'd100; facing = 1'b1;
        frameStart();
        drawLine(205, 98, 133);
        state = 2'd1;
        frameStart();
        drawLine(230, 99, 132);
        drawLine(231, 99, 132);

        // Idle animation over 30 frames, then CHARGE and back to IDLE.
        state = 2'd0; facing = 1'b0;
        for (int f = 0; f < 30; f++) begin
            frameStart();
            drawLine(201, 100, 103);
        end
        state = 2'd1;
        frameStart();
        drawLine(201, 100, 103);
        state = 2'd0;
        frameStart();
        drawLine(201, 100, 103);
        state = 2'd3;
        frameStart();
        drawLine(201, 100, 103);

        // Sprite clipped at the bottom-right corner of the screen.
        state = 2'd0; posX = 12'd1010; posY = 12'd760;
        frameStart();
        drawLine(759, 1005, 1030);
        drawLine(760, 1005, 1030);
        drawLine(761, 0, 20);
        drawLine(767, 1005, 1030);
        drawLine(768, 1005, 1030);
        drawLine(0, 0, 3);

        repeat (4) @(posedge clk);
        #2;
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatch++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
